riscv16_main_control: RTL

- Multi-cycle main control FSM for the 16-bit RISC core.
- Decodes the 4-bit instruction opcode and sequences fetch, decode, execute, memory and writeback.
- Produces the 2-bit alu_op class that the ALU control block expands into alu_ctrl, plus all datapath enables.
- Sits between the instruction register and the datapath; it is the producer of the alu_op/opcode interface.

---
 rtl/riscv16_pkg.sv | 68 ++++++
 rtl/riscv16_main_control_if.sv | 44 ++++
 rtl/riscv16_ctrl_decode.sv | 64 ++++++
 rtl/riscv16_main_control.sv | 98 +++++++++
 4 files changed

// File: rtl/riscv16_pkg.sv
// Shared definitions for the 16-bit RISC main control: opcodes, alu_op/pc_src codes,
// FSM states and the packed control-output bundle.
package riscv16_pkg;

    localparam logic [3:0] OPC_LW  = 4'b0000;
    localparam logic [3:0] OPC_SW  = 4'b0001;
    localparam logic [3:0] OPC_ADD = 4'b0010;
    localparam logic [3:0] OPC_SUB = 4'b0011;
    localparam logic [3:0] OPC_INV = 4'b0100;
    localparam logic [3:0] OPC_LSL = 4'b0101;
    localparam logic [3:0] OPC_LSR = 4'b0110;
    localparam logic [3:0] OPC_AND = 4'b0111;
    localparam logic [3:0] OPC_OR  = 4'b1000;
    localparam logic [3:0] OPC_SLT = 4'b1001;
    localparam logic [3:0] OPC_BEQ = 4'b1011;
    localparam logic [3:0] OPC_BNE = 4'b1100;
    localparam logic [3:0] OPC_JMP = 4'b1101;

    localparam logic [1:0] AOP_RTYPE = 2'b00;
    localparam logic [1:0] AOP_SUB   = 2'b01;
    localparam logic [1:0] AOP_ADD   = 2'b10;

    localparam logic [1:0] PCS_SEQ = 2'b00;
    localparam logic [1:0] PCS_BR  = 2'b01;
    localparam logic [1:0] PCS_JMP = 2'b10;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
`ifdef CTRL_ILLEGAL_TRAP_EN
        , TRAP = 3'd5
`endif
    } state_t;

    typedef struct packed {
        logic       imem_req;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic [1:0] alu_op;
        logic       alu_src;
        logic       reg_dst;
        logic       reg_write;
        logic       mem_to_reg;
        logic       dmem_read;
        logic       dmem_write;
`ifdef CTRL_ILLEGAL_TRAP_EN
        logic       illegal;
`endif
    } ctrl_out_t;

    function automatic logic opc_is_rtype(input logic [3:0] opc);
        return (opc >= OPC_ADD) && (opc <= OPC_SLT);
    endfunction

    function automatic logic opc_is_mem(input logic [3:0] opc);
        return (opc == OPC_LW) || (opc == OPC_SW);
    endfunction

    // 1010 sits between SLT and BEQ; 1110/1111 are above JMP.
    function automatic logic opc_is_defined(input logic [3:0] opc);
        return (opc != 4'b1010) && (opc <= OPC_JMP);
    endfunction

endpackage

// File: rtl/riscv16_main_control_if.sv
// Control-to-datapath bundle: instruction/flag/ready inputs and all datapath enables.
// The illegal line exists only when CTRL_ILLEGAL_TRAP_EN is defined.
interface riscv16_main_control_if #(
    parameter int OPC_W = 4,
    parameter int AOP_W = 2
);
    logic [OPC_W-1:0] opcode;
    logic             zero;
    logic             imem_ready;
    logic             dmem_ready;
    logic             imem_req;
    logic             ir_write;
    logic             pc_write;
    logic [1:0]       pc_src;
    logic [AOP_W-1:0] alu_op;
    logic             alu_src;
    logic             reg_dst;
    logic             reg_write;
    logic             mem_to_reg;
    logic             dmem_read;
    logic             dmem_write;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic             illegal;
`endif

    modport master (
        input  opcode, zero, imem_ready, dmem_ready,
        output imem_req, ir_write, pc_write, pc_src, alu_op, alu_src,
               reg_dst, reg_write, mem_to_reg, dmem_read, dmem_write
`ifdef CTRL_ILLEGAL_TRAP_EN
        , output illegal
`endif
    );

    modport slave (
        output opcode, zero, imem_ready, dmem_ready,
        input  imem_req, ir_write, pc_write, pc_src, alu_op, alu_src,
               reg_dst, reg_write, mem_to_reg, dmem_read, dmem_write
`ifdef CTRL_ILLEGAL_TRAP_EN
        , input illegal
`endif
    );

endinterface

// File: rtl/riscv16_ctrl_decode.sv
// Moore output decode of {state, latched opcode, zero}; FETCH additionally looks at
// imem_ready so the IR/PC load lands on the ready cycle.
module riscv16_ctrl_decode
    import riscv16_pkg::*;
(
    input  state_t     i_state,
    input  logic [3:0] i_opcode,
    input  logic       i_zero,
    input  logic       i_imem_ready,
    output ctrl_out_t  o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            FETCH: begin
                o_ctrl.imem_req = 1'b1;
                if (i_imem_ready) begin
                    o_ctrl.ir_write = 1'b1;
                    o_ctrl.pc_write = 1'b1;
                    o_ctrl.pc_src   = PCS_SEQ;
                end
            end
            EXEC: begin
                if (opc_is_rtype(i_opcode)) begin
                    o_ctrl.alu_op  = AOP_RTYPE;
                    o_ctrl.alu_src = 1'b0;
                end else if (opc_is_mem(i_opcode)) begin
                    o_ctrl.alu_op  = AOP_ADD;
                    o_ctrl.alu_src = 1'b1;
                end else if (i_opcode == OPC_BEQ || i_opcode == OPC_BNE) begin
                    o_ctrl.alu_op   = AOP_SUB;
                    o_ctrl.pc_src   = PCS_BR;
                    o_ctrl.pc_write = (i_opcode == OPC_BEQ) ? i_zero : ~i_zero;
                end else if (i_opcode == OPC_JMP) begin
                    o_ctrl.pc_src   = PCS_JMP;
                    o_ctrl.pc_write = 1'b1;
                end
            end
            MEM: begin
                // Address stays on the ALU for the whole access.
                o_ctrl.alu_op     = AOP_ADD;
                o_ctrl.alu_src    = 1'b1;
                o_ctrl.dmem_read  = (i_opcode == OPC_LW);
                o_ctrl.dmem_write = (i_opcode == OPC_SW);
            end
            WB: begin
                o_ctrl.reg_write = 1'b1;
                if (i_opcode == OPC_LW) begin
                    o_ctrl.mem_to_reg = 1'b1;
                end else begin
                    o_ctrl.reg_dst = 1'b1;
                end
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            TRAP: begin
                o_ctrl.illegal = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/riscv16_main_control.sv
// Multi-cycle main control FSM (FETCH/DECODE/EXEC/MEM/WB) for the 16-bit RISC core.
// Define CTRL_ILLEGAL_TRAP_EN to trap undefined opcodes in TRAP with the illegal output.
module riscv16_main_control
    import riscv16_pkg::*;
#(
    parameter int OPC_W = 4,
    parameter int AOP_W = 2
) (
    input logic                    clk,
    input logic                    rst,
    riscv16_main_control_if.master bus
);

    state_t           r_state;
    state_t           w_next;
    logic [OPC_W-1:0] r_opcode;
    ctrl_out_t        w_ctrl;
    ctrl_out_t        w_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= FETCH;
            r_opcode <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == DECODE) begin
                r_opcode <= bus.opcode;
            end
        end
    end

    // Only DECODE looks at the live opcode; later states use the latched copy.
    always_comb begin
        w_next = r_state;
        case (r_state)
            FETCH: begin
                if (bus.imem_ready) w_next = DECODE;
            end
            DECODE: begin
                if (opc_is_defined(bus.opcode)) begin
                    w_next = EXEC;
                end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    w_next = TRAP;
`else
                    w_next = FETCH;
`endif
                end
            end
            EXEC: begin
                if (opc_is_rtype(r_opcode))    w_next = WB;
                else if (opc_is_mem(r_opcode)) w_next = MEM;
                else                           w_next = FETCH;
            end
            MEM: begin
                if (bus.dmem_ready) w_next = (r_opcode == OPC_LW) ? WB : FETCH;
            end
            WB: begin
                w_next = FETCH;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            TRAP: begin
                w_next = TRAP;
            end
`endif
            default: begin
                w_next = FETCH;
            end
        endcase
    end

    riscv16_ctrl_decode u_decode (
        .i_state      (r_state),
        .i_opcode     (r_opcode),
        .i_zero       (bus.zero),
        .i_imem_ready (bus.imem_ready),
        .o_ctrl       (w_ctrl)
    );

    // Reset blanks every output immediately, before the state register has flipped.
    assign w_out = rst ? '0 : w_ctrl;

    assign bus.imem_req   = w_out.imem_req;
    assign bus.ir_write   = w_out.ir_write;
    assign bus.pc_write   = w_out.pc_write;
    assign bus.pc_src     = w_out.pc_src;
    assign bus.alu_op     = w_out.alu_op;
    assign bus.alu_src    = w_out.alu_src;
    assign bus.reg_dst    = w_out.reg_dst;
    assign bus.reg_write  = w_out.reg_write;
    assign bus.mem_to_reg = w_out.mem_to_reg;
    assign bus.dmem_read  = w_out.dmem_read;
    assign bus.dmem_write = w_out.dmem_write;
`ifdef CTRL_ILLEGAL_TRAP_EN
    assign bus.illegal    = w_out.illegal;
`endif

endmodule
